// File: rtl/rr_dec_arbiter.sv
// rr_dec_arbiter: round-robin arbiter driving a decoder-with-enable grant path.
// A registered binary owner index is decoded into a one-hot grant, gated by
// gnt_valid. Each grant is held until the owner raises done or drops its
// request, and is always followed by at least one idle bubble cycle.
// Optional feature: define RR_DEC_ARBITER_TIMEOUT_EN to force release of a
// grant held for MAX_HOLD cycles (timeout pulses in that last grant cycle).
// Without the macro, timeout is tied low and grants never expire.
module rr_dec_arbiter #(
    parameter int N        = 4,
    parameter int IDXW     = 2,
    parameter int MAX_HOLD = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            done,
    output logic [IDXW-1:0] gnt_idx,
    output logic [N-1:0]    gnt,
    output logic            gnt_valid,
    output logic            timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [IDXW-1:0] gnt_idx_q;
    logic [IDXW-1:0] gnt_idx_d;
    logic [IDXW-1:0] last_q;
    logic [IDXW-1:0] last_d;
    logic [IDXW-1:0] pick_idx;
    logic            pick_found;
    logic            owner_release;
    logic            hold_expire;

    // Round-robin search: first requester after the last owner, wrapping within 0..N-1.
    always_comb begin
        int              cand;
        logic [IDXW-1:0] cand_idx;
        pick_idx   = '0;
        pick_found = 1'b0;
        cand       = 0;
        cand_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            cand     = (int'(last_q) + k) % N;
            cand_idx = IDXW'(cand);
            if (!pick_found && req[cand_idx]) begin
                pick_idx   = cand_idx;
                pick_found = 1'b1;
            end
        end
    end

    // The owner gives the resource back by signalling done or withdrawing its request.
    assign owner_release = done | ~req[gnt_idx_q];

`ifdef RR_DEC_ARBITER_TIMEOUT_EN
    localparam int CNTW = $clog2(MAX_HOLD + 1);

    logic [CNTW-1:0] hold_cnt_q;

    // Count cycles already spent in GRANT; idle cycles keep it at zero so each grant starts fresh.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
        end else if (state_q == GRANT) begin
            hold_cnt_q <= hold_cnt_q + CNTW'(1);
        end else begin
            hold_cnt_q <= '0;
        end
    end

    // The counter reaches MAX_HOLD at the edge closing the MAX_HOLD-th grant cycle.
    assign hold_expire = (state_q == GRANT) && (hold_cnt_q == CNTW'(MAX_HOLD - 1));
    // A normal release in the same cycle takes precedence, so no timeout is flagged then.
    assign timeout     = hold_expire & ~owner_release;
`else
    logic unused_max_hold;

    assign unused_max_hold = (MAX_HOLD != 0);
    assign hold_expire     = 1'b0;
    assign timeout         = 1'b0;
`endif

    // State register, owner index and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_idx_q <= '0;
            last_q    <= IDXW'(N - 1);
        end else begin
            state_q   <= state_d;
            gnt_idx_q <= gnt_idx_d;
            last_q    <= last_d;
        end
    end

    // Next-state: grant the picked requester from IDLE, release back to IDLE from GRANT.
    always_comb begin
        state_d   = state_q;
        gnt_idx_d = gnt_idx_q;
        last_d    = last_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gnt_idx_d = pick_idx;
                    state_d   = GRANT;
                end
            end
            GRANT: begin
                if (owner_release || hold_expire) begin
                    last_d  = gnt_idx_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign gnt_valid = (state_q == GRANT);
    assign gnt_idx   = gnt_idx_q;

    // Decoder with enable: only registered signals feed it, so gnt is one-hot or zero.
    always_comb begin
        gnt = '0;
        for (int i = 0; i < N; i++) begin
            gnt[i] = gnt_valid & (gnt_idx_q == IDXW'(i));
        end
    end

endmodule

// File: tb/tb_rr_dec_arbiter.sv
// tb_rr_dec_arbiter: directed vector table, multi-cycle corner sequences and
// randomized traffic against a behavioural round-robin model (N=4).
module tb_rr_dec_arbiter;

    localparam int N        = 4;
    localparam int IDXW     = 2;
    localparam int MAX_HOLD = 15;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req;
    logic            done;
    logic [IDXW-1:0] gnt_idx;
    logic [N-1:0]    gnt;
    logic            gnt_valid;
    logic            timeout;

    int checks;
    int failures;

    // Behavioural model: current owner (-1 = none), pointer, shown index, cycles held.
    int m_owner;
    int m_last;
    int m_idx;
    int m_held;
    logic to_sample;

    typedef struct {
        logic [N-1:0]    req;
        logic            done;
        logic            rst_n;
        logic            exp_v;
        logic [IDXW-1:0] exp_idx;
        logic [N-1:0]    exp_gnt;
    } vec_t;

    vec_t tbl[$];

    rr_dec_arbiter #(
        .N        (N),
        .IDXW     (IDXW),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt_idx   (gnt_idx),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic [N-1:0] r, input logic d, input logic rn,
                       input logic v, input logic [IDXW-1:0] idx, input logic [N-1:0] g);
        vec_t e;
        e.req = r; e.done = d; e.rst_n = rn;
        e.exp_v = v; e.exp_idx = idx; e.exp_gnt = g;
        tbl.push_back(e);
    endtask

    // Apply one cycle of inputs: check timeout mid-cycle, advance the model at the
    // edge, then compare the registered outputs just after the edge.
    task automatic step(input logic [N-1:0] r, input logic d, input logic rn);
        logic         exp_to;
        logic         rel;
        logic [N-1:0] eg;
        req = r; done = d; rst_n = rn;
        @(negedge clk);
        to_sample = timeout;
        exp_to = 1'b0;
`ifdef RR_DEC_ARBITER_TIMEOUT_EN
        if (m_owner >= 0 && !d && r[m_owner[1:0]] && m_held == MAX_HOLD) exp_to = 1'b1;
`endif
        chk("timeout", 32'(to_sample), 32'(exp_to));
        if (!rn) begin
            m_owner = -1; m_last = N - 1; m_idx = 0; m_held = 0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (m_owner < 0 && r[c[1:0]]) begin
                    m_owner = c; m_idx = c; m_held = 1;
                end
            end
        end else begin
            rel = d || !r[m_owner[1:0]];
`ifdef RR_DEC_ARBITER_TIMEOUT_EN
            if (m_held >= MAX_HOLD) rel = 1'b1;
`endif
            if (rel) begin
                m_last = m_owner; m_owner = -1;
            end else begin
                m_held++;
            end
        end
        @(posedge clk);
        #1;
        eg = '0;
        if (m_owner >= 0) eg[m_owner[1:0]] = 1'b1;
        chk("model_valid", 32'(gnt_valid), 32'(m_owner >= 0));
        chk("model_idx", 32'(gnt_idx), 32'(m_idx));
        chk("model_gnt", 32'(gnt), 32'(eg));
    endtask

    initial begin
        logic [N-1:0] r;
        logic         d;
        logic         rn;
        int           vcnt;
        int           to_seen;

        checks = 0; failures = 0;
        m_owner = -1; m_last = N - 1; m_idx = 0; m_held = 0;
        to_sample = 1'b0;
        req = '0; done = 1'b0; rst_n = 1'b0;

        // reset held two cycles, then idle
        add(4'b0000, 0, 0, 0, 0, 4'b0000);
        add(4'b0000, 0, 0, 0, 0, 4'b0000);
        for (int i = 0; i < 5; i++) add(4'b0000, 0, 1, 0, 0, 4'b0000);
        // single requester, release by done, re-grant after one bubble
        add(4'b0100, 0, 1, 1, 2, 4'b0100);
        add(4'b0100, 1, 1, 0, 2, 4'b0000);
        add(4'b0100, 0, 1, 1, 2, 4'b0100);
        add(4'b0100, 1, 1, 0, 2, 4'b0000);
        // reset, then rotation with all requesting
        add(4'b0000, 0, 0, 0, 0, 4'b0000);
        add(4'b1111, 0, 1, 1, 0, 4'b0001);
        add(4'b1111, 1, 1, 0, 0, 4'b0000);
        add(4'b1111, 0, 1, 1, 1, 4'b0010);
        add(4'b1111, 1, 1, 0, 1, 4'b0000);
        add(4'b1111, 0, 1, 1, 2, 4'b0100);
        add(4'b1111, 1, 1, 0, 2, 4'b0000);
        add(4'b1111, 0, 1, 1, 3, 4'b1000);
        add(4'b1111, 1, 1, 0, 3, 4'b0000);
        add(4'b1111, 0, 1, 1, 0, 4'b0001);
        add(4'b1111, 1, 1, 0, 0, 4'b0000);
        // wrap-around priority
        add(4'b1000, 0, 1, 1, 3, 4'b1000);
        add(4'b1000, 1, 1, 0, 3, 4'b0000);
        add(4'b1001, 0, 1, 1, 0, 4'b0001);
        add(4'b1001, 1, 1, 0, 0, 4'b0000);
        add(4'b1001, 0, 1, 1, 3, 4'b1000);
        add(4'b1001, 1, 1, 0, 3, 4'b0000);
        // request drop releases without done
        add(4'b0010, 0, 1, 1, 1, 4'b0010);
        add(4'b0000, 0, 1, 0, 1, 4'b0000);
        // reset in the middle of a grant
        add(4'b0100, 0, 1, 1, 2, 4'b0100);
        add(4'b0100, 0, 0, 0, 0, 4'b0000);
        add(4'b1111, 0, 1, 1, 0, 4'b0001);
        add(4'b0000, 0, 1, 0, 0, 4'b0000);
        // done in IDLE ignored; non-owner requests ignored during GRANT
        add(4'b0000, 1, 1, 0, 0, 4'b0000);
        add(4'b0001, 0, 1, 1, 0, 4'b0001);
        add(4'b1111, 0, 1, 1, 0, 4'b0001);
        add(4'b1111, 1, 1, 0, 0, 4'b0000);
        add(4'b1111, 0, 1, 1, 1, 4'b0010);
        add(4'b0000, 0, 1, 0, 1, 4'b0000);

        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].req, tbl[i].done, tbl[i].rst_n);
            chk($sformatf("tbl_valid[%0d]", i), 32'(gnt_valid), 32'(tbl[i].exp_v));
            chk($sformatf("tbl_idx[%0d]", i), 32'(gnt_idx), 32'(tbl[i].exp_idx));
            chk($sformatf("tbl_gnt[%0d]", i), 32'(gnt), 32'(tbl[i].exp_gnt));
        end

`ifdef RR_DEC_ARBITER_TIMEOUT_EN
        // forced release after MAX_HOLD cycles, one timeout pulse, one bubble, re-grant
        step(4'b0010, 0, 1);
        vcnt = 0; to_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (!gnt_valid) break;
            vcnt++;
            step(4'b0010, 0, 1);
            if (to_sample) to_seen++;
        end
        chk("hold_len", 32'(vcnt), 32'(MAX_HOLD));
        chk("timeout_pulses", 32'(to_seen), 32'd1);
        chk("bubble_valid", 32'(gnt_valid), 32'd0);
        step(4'b0010, 0, 1);
        chk("regrant_after_timeout", 32'(gnt_valid), 32'd1);
        // done in the same cycle the limit is reached: normal release, no timeout
        for (int i = 0; i < MAX_HOLD - 1; i++) step(4'b0010, 0, 1);
        step(4'b0010, 1, 1);
        chk("done_at_limit_timeout", 32'(to_sample), 32'd0);
        chk("done_at_limit_valid", 32'(gnt_valid), 32'd0);
`else
        // without the hold limit a grant lasts as long as the owner keeps it
        step(4'b0010, 0, 1);
        vcnt = 0; to_seen = 0;
        for (int i = 0; i < 120; i++) begin
            if (gnt_valid) vcnt++;
            step(4'b0010, 0, 1);
            if (to_sample) to_seen++;
        end
        chk("long_hold_len", 32'(vcnt), 32'd120);
        chk("long_hold_timeouts", 32'(to_seen), 32'd0);
        step(4'b0010, 1, 1);
        chk("long_hold_release", 32'(gnt_valid), 32'd0);
`endif

        // randomized traffic against the model
        r = '0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            d  = ($urandom_range(0, 3) == 0);
            rn = ($urandom_range(0, 49) != 0);
            step(r, d, rn);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
